// File: rtl/prog_loader.sv
// prog_loader: loads a length/payload/checksum byte stream into instruction memory and serves CPU fetches.
// Ports: clk, rst_n (sync, active-low); load_valid/load_data/load_ready host byte stream;
//        reload restart pulse; fetch_addr -> fetch_data (1-cycle registered read);
//        cpu_run verified image resident; err last load bad checksum; loaded_len payload bytes written.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] HALT_OP = 8'h70
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              cpu_run,
    output logic              err,
    output logic [ADDR_W:0]   loaded_len
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, DATA, CHECK, DONE, ERROR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sum;
    logic [ADDR_W:0]   rem;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              take;

    assign load_ready = state == IDLE || state == DATA || state == CHECK;
    assign take = load_valid && load_ready && !reload;

    always_ff @(posedge clk)
        if (rst_n && take && state == DATA)
            mem[addr] <= load_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            sum        <= '0;
            rem        <= '0;
            cpu_run    <= 1'b0;
            err        <= 1'b0;
            loaded_len <= '0;
            fetch_data <= HALT_OP;
        end else begin
            // Read decision uses the pre-edge state, so a reload cycle in DONE still returns memory data.
            fetch_data <= state == DONE ? mem[fetch_addr] : HALT_OP;
            if (reload) begin
                state   <= IDLE;
                addr    <= '0;
                sum     <= '0;
                rem     <= '0;
                err     <= 1'b0;
                cpu_run <= 1'b0;
            end else if (take) begin
                case (state)
                    IDLE: begin
                        rem        <= load_data == '0 ? FULL : (ADDR_W + 1)'(load_data);
                        addr       <= '0;
                        sum        <= '0;
                        loaded_len <= '0;
                        state      <= DATA;
                    end
                    DATA: begin
                        addr       <= addr + 1'b1;
                        sum        <= sum + load_data;
                        loaded_len <= loaded_len + 1'b1;
                        rem        <= rem - 1'b1;
                        state      <= rem == 1 ? CHECK : DATA;
                    end
                    CHECK: begin
                        state   <= load_data == sum ? DONE : ERROR;
                        err     <= load_data != sum;
                        cpu_run <= load_data == sum;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready;
    logic       reload = 1'b0;
    logic [7:0] fetch_addr = 8'h00;
    logic [7:0] fetch_data;
    logic       cpu_run;
    logic       err;
    logic [8:0] loaded_len;
    int         n_tests = 0;
    int         n_fail = 0;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .reload(reload), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .cpu_run(cpu_run), .err(err), .loaded_len(loaded_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [7:0] a, input logic [7:0] exp);
        fetch_addr = a;
        tick();
        check(tag, fetch_data, exp);
    endtask

    initial begin
        tick();
        check("rst_cpu_run", cpu_run, 0);
        check("rst_err", err, 0);
        check("rst_len", loaded_len, 0);
        check("rst_fetch", fetch_data, 8'h70);
        check("rst_ready", load_ready, 1);
        rst_n = 1'b1;

        // Good 5-byte image
        send(8'h05); send(8'h01); send(8'h00); send(8'h04); send(8'h00); send(8'h70);
        check("t1_run_before_ck", cpu_run, 0);
        send(8'h75);
        check("t1_run", cpu_run, 1);
        check("t1_err", err, 0);
        check("t1_len", loaded_len, 5);
        check("t1_ready", load_ready, 0);
        fetch("t1_f2", 8'h02, 8'h04);
        fetch("t1_f4", 8'h04, 8'h70);

        // Bad checksum
        pulse_reload();
        check("t2_ready_idle", load_ready, 1);
        check("t2_run_cleared", cpu_run, 0);
        send(8'h05); send(8'h01); send(8'h00); send(8'h04); send(8'h00); send(8'h70); send(8'h74);
        check("t2_err", err, 1);
        check("t2_run", cpu_run, 0);
        check("t2_ready", load_ready, 0);
        fetch("t2_f2", 8'h02, 8'h70);
        pulse_reload();
        check("t2_err_cleared", err, 0);
        check("t2_ready_after", load_ready, 1);

        // Full-depth image via length 0
        send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i));
        send(8'h80);
        check("t3_run", cpu_run, 1);
        check("t3_len", loaded_len, 256);
        fetch("t3_fff", 8'hFF, 8'hFF);
        fetch("t3_f00", 8'h00, 8'h00);

        // Reload in DONE still returns memory data that cycle
        fetch_addr = 8'h05;
        pulse_reload();
        check("t4_reload_fetch", fetch_data, 8'h05);
        tick();
        check("t4_halt_after", fetch_data, 8'h70);

        // Gapped stream
        load_data = 8'hEE;
        send(8'h03); tick();
        send(8'hAA); tick(); tick();
        send(8'hBB); tick(); tick(); tick();
        send(8'hCC); tick();
        send(8'h31);
        check("t4_run", cpu_run, 1);
        check("t4_len", loaded_len, 3);
        send(8'h55);
        check("t4_ignored_len", loaded_len, 3);
        check("t4_ignored_run", cpu_run, 1);
        fetch("t4_f0", 8'h00, 8'hAA);
        fetch("t4_f1", 8'h01, 8'hBB);
        fetch("t4_f2", 8'h02, 8'hCC);
        fetch("t4_f3", 8'h03, 8'h03);

        // Reload mid-payload together with a byte
        pulse_reload();
        send(8'h05); send(8'h01); send(8'h02);
        load_valid = 1'b1;
        load_data  = 8'h03;
        pulse_reload();
        load_valid = 1'b0;
        check("t5_ready", load_ready, 1);
        check("t5_len_kept", loaded_len, 2);
        send(8'h02);
        check("t5_len_cleared", loaded_len, 0);
        send(8'h11); send(8'h22); send(8'h33);
        check("t5_run", cpu_run, 1);
        check("t5_len", loaded_len, 2);
        fetch("t5_f0", 8'h00, 8'h11);
        fetch("t5_f1", 8'h01, 8'h22);
        fetch("t5_f2", 8'h02, 8'hCC);

        // Reset while running
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_run", cpu_run, 0);
        check("t6_err", err, 0);
        check("t6_len", loaded_len, 0);
        check("t6_fetch", fetch_data, 8'h70);
        send(8'h01); send(8'h70); send(8'h70);
        check("t6_run_again", cpu_run, 1);
        check("t6_len_again", loaded_len, 1);
        fetch_addr = 8'h01;
        tick();
        check("t6_f1_kept", fetch_data, 8'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
